// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
package seg7_pkg;

  // Active-high segment pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Nibble to active-high segments {G,F,E,D,C,B,A}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment decoder.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure lookup, active-high segments.
  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-frame snapshot, leading-zero
// suppression, per-digit enable/DP, brightness PWM and registered outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TICK_DIV       = 100_000,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          CAT_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [4*NUM_DIGITS-1:0] hex_val_i,
  input  logic [NUM_DIGITS-1:0]   dp_en_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    lz_suppress_i,
  input  logic [3:0]              brightness_i,
  output logic [NUM_DIGITS-1:0]   seg_an_o,
  output logic [7:0]              seg_cat_o,
  output logic                    frame_start_o
);

  localparam int unsigned SelW  = sel_width(NUM_DIGITS);
  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam logic [SelW-1:0]       LastSel  = SelW'(NUM_DIGITS - 1);
  localparam logic [TickW-1:0]      LastTick = TickW'(TICK_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AnOff    = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [7:0]            CatOff   = CAT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [TickW-1:0]        tick_q, tick_d;
  logic [SelW-1:0]         sel_q, sel_d;
  logic [3:0]              pwm_q;
  logic                    first_q;
  logic [4*NUM_DIGITS-1:0] snap_hex_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_en_q;
  logic                    snap_lz_q;
  logic                    frame_start_q;
  logic [NUM_DIGITS-1:0]   seg_an_q, seg_an_d;
  logic [7:0]              seg_cat_q, seg_cat_d;

  logic                    tick_wrap, take_snap, visible, pwm_on, all_zero;
  logic [NUM_DIGITS-1:0]   lz_mask, an_onehot;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;
  logic [7:0]              cat_raw;

  // Scan counters; snapshot on entry to digit 0 and on the first cycle out of reset.
  always_comb begin
    tick_wrap = (tick_q == LastTick);
    tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
    sel_d     = sel_q;
    if (tick_wrap) begin
      sel_d = (sel_q == LastSel) ? '0 : sel_q + 1'b1;
    end
    take_snap = first_q | (tick_wrap & (sel_q == LastSel));
  end

  // Leading-zero mask: walk from the most significant digit down; digit 0 always shows.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero   = all_zero & (snap_hex_q[4*k +: 4] == 4'h0);
      lz_mask[k] = snap_lz_q & all_zero & (k != 0);
    end
  end

  assign cur_nibble = snap_hex_q[{sel_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  // Output stage next-state; anodes blanked on the last tick to avoid ghosting.
  always_comb begin
    visible          = snap_en_q[sel_q] & ~lz_mask[sel_q];
    pwm_on           = (pwm_q <= brightness_i);
    an_onehot        = '0;
    an_onehot[sel_q] = visible & pwm_on & ~tick_wrap;
    seg_an_d         = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
    cat_raw          = visible ? {snap_dp_q[sel_q], cur_seg} : {1'b0, SEG_BLANK};
    seg_cat_d        = CAT_ACTIVE_LOW ? ~cat_raw : cat_raw;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_q        <= '0;
      sel_q         <= '0;
      pwm_q         <= '0;
      first_q       <= 1'b1;
      snap_hex_q    <= '0;
      snap_dp_q     <= '0;
      snap_en_q     <= '0;
      snap_lz_q     <= 1'b0;
      frame_start_q <= 1'b0;
      seg_an_q      <= AnOff;
      seg_cat_q     <= CatOff;
    end else begin
      tick_q        <= tick_d;
      sel_q         <= sel_d;
      pwm_q         <= pwm_q + 4'd1;
      first_q       <= 1'b0;
      frame_start_q <= take_snap;
      seg_an_q      <= seg_an_d;
      seg_cat_q     <= seg_cat_d;
      if (take_snap) begin
        snap_hex_q <= hex_val_i;
        snap_dp_q  <= dp_en_i;
        snap_en_q  <= digit_en_i;
        snap_lz_q  <= lz_suppress_i;
      end
    end
  end

  assign seg_an_o      = seg_an_q;
  assign seg_cat_o     = seg_cat_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: frame vectors, snapshot, reset, PWM and generics.
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 4 digits, short ticks, active-low.
  logic [15:0] a_hex;
  logic [3:0]  a_dp, a_en, a_br, a_an;
  logic        a_lz, a_fs;
  logic [7:0]  a_cat;
  // DUT P: PWM observation with long ticks.
  logic [15:0] p_hex;
  logic [3:0]  p_dp, p_en, p_br, p_an;
  logic        p_lz, p_fs;
  logic [7:0]  p_cat;
  // DUT G: 6 digits, active-high polarity.
  logic [23:0] g_hex;
  logic [5:0]  g_dp, g_en, g_an;
  logic [3:0]  g_br;
  logic        g_lz, g_fs;
  logic [7:0]  g_cat;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(4), .AN_ACTIVE_LOW(1'b1), .CAT_ACTIVE_LOW(1'b1))
  dut_a (
    .clk_i(clk), .reset_i(reset), .hex_val_i(a_hex), .dp_en_i(a_dp), .digit_en_i(a_en),
    .lz_suppress_i(a_lz), .brightness_i(a_br), .seg_an_o(a_an), .seg_cat_o(a_cat),
    .frame_start_o(a_fs)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(64), .AN_ACTIVE_LOW(1'b1), .CAT_ACTIVE_LOW(1'b1))
  dut_p (
    .clk_i(clk), .reset_i(reset), .hex_val_i(p_hex), .dp_en_i(p_dp), .digit_en_i(p_en),
    .lz_suppress_i(p_lz), .brightness_i(p_br), .seg_an_o(p_an), .seg_cat_o(p_cat),
    .frame_start_o(p_fs)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(6), .TICK_DIV(4), .AN_ACTIVE_LOW(1'b0), .CAT_ACTIVE_LOW(1'b0))
  dut_g (
    .clk_i(clk), .reset_i(reset), .hex_val_i(g_hex), .dp_en_i(g_dp), .digit_en_i(g_en),
    .lz_suppress_i(g_lz), .brightness_i(g_br), .seg_an_o(g_an), .seg_cat_o(g_cat),
    .frame_start_o(g_fs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [31:0] cats;  // expected active-low cathodes {d3,d2,d1,d0}
    logic [3:0]  vis;   // expected visible digits
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a frame_start pulse seen after the call.
  task automatic wait_frame(input int which);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = a_fs;
        1:       seen = p_fs;
        default: seen = g_fs;
      endcase
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout dut%0d: got no frame_start, expected one", which);
    end
  endtask

  // Check DUT A over frame cycles c0..c1 (cycle 0 = first after frame_start).
  task automatic check_a(input int c0, input int c1, input logic [31:0] cats,
                         input logic [3:0] vis, input string name);
    logic [3:0] exp_an;
    logic [7:0] exp_cat;
    int d, ph;
    for (int c = c0; c <= c1; c++) begin
      @(negedge clk);
      d  = c / 4;
      ph = c % 4;
      exp_an  = (ph == 3 || !vis[d]) ? 4'hF : ~(4'b0001 << d);
      exp_cat = vis[d] ? cats[8*d +: 8] : 8'hFF;
      chk($sformatf("%s an c%0d", name, c), {28'd0, a_an}, {28'd0, exp_an});
      chk($sformatf("%s cat c%0d", name, c), {24'd0, a_cat}, {24'd0, exp_cat});
      chk($sformatf("%s fs c%0d", name, c), {31'd0, a_fs}, {31'd0, (c == 15)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic others_ok;
    logic [5:0] g_exp;

    vecs[0] = '{16'h12AF, 4'h0, 4'hF, 1'b0, 32'hF9A4_888E, 4'hF};
    vecs[1] = '{16'h0030, 4'h0, 4'hF, 1'b1, 32'hFFFF_B0C0, 4'h3};
    vecs[2] = '{16'h0000, 4'h0, 4'hF, 1'b1, 32'hFFFF_FFC0, 4'h1};
    vecs[3] = '{16'h0000, 4'h0, 4'hF, 1'b0, 32'hC0C0_C0C0, 4'hF};
    vecs[4] = '{16'h4567, 4'h4, 4'hF, 1'b0, 32'h9912_82F8, 4'hF};
    vecs[5] = '{16'h9BCD, 4'h0, 4'hB, 1'b0, 32'h9083_C6A1, 4'hB};
    vecs[6] = '{16'h0E00, 4'h0, 4'hF, 1'b1, 32'hFF86_C0C0, 4'h7};
    vecs[7] = '{16'h8F5B, 4'h9, 4'hF, 1'b1, 32'h008E_9203, 4'hF};

    a_hex = vecs[0].hex; a_dp = vecs[0].dp; a_en = vecs[0].en; a_lz = vecs[0].lz; a_br = 4'hF;
    p_hex = 16'h1234; p_dp = 4'h0; p_en = 4'hF; p_lz = 1'b0; p_br = 4'd3;
    g_hex = 24'h888888; g_dp = 6'h00; g_en = 6'h3F; g_lz = 1'b0; g_br = 4'hF;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset a_an", {28'd0, a_an}, 32'hF);
    chk("reset a_cat", {24'd0, a_cat}, 32'hFF);
    chk("reset a_fs", {31'd0, a_fs}, 32'h0);
    chk("reset g_an", {26'd0, g_an}, 32'h0);
    chk("reset g_cat", {24'd0, g_cat}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset a_an", {28'd0, a_an}, 32'hF);
    chk("post-reset a_cat", {24'd0, a_cat}, 32'hFF);
    chk("post-reset a_fs", {31'd0, a_fs}, 32'h1);

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      a_hex = vecs[v].hex; a_dp = vecs[v].dp; a_en = vecs[v].en; a_lz = vecs[v].lz;
      wait_frame(0);
      check_a(0, 15, vecs[v].cats, vecs[v].vis, $sformatf("vec%0d", v));
    end

    // Snapshot: mid-frame change is invisible until the next frame.
    a_hex = 16'h1111; a_dp = 4'h0; a_en = 4'hF; a_lz = 1'b0;
    wait_frame(0);
    check_a(0, 5, 32'hF9F9_F9F9, 4'hF, "snap pre");
    a_hex = 16'h2222;
    check_a(6, 15, 32'hF9F9_F9F9, 4'hF, "snap hold");
    check_a(0, 15, 32'hA4A4_A4A4, 4'hF, "snap new");

    // Reset mid-scan, then a clean frame restarts from digit 0.
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset a_an", {28'd0, a_an}, 32'hF);
    chk("midreset a_cat", {24'd0, a_cat}, 32'hFF);
    chk("midreset a_fs", {31'd0, a_fs}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset release a_an", {28'd0, a_an}, 32'hF);
    chk("midreset release a_fs", {31'd0, a_fs}, 32'h1);
    wait_frame(0);
    check_a(0, 15, 32'hA4A4_A4A4, 4'hF, "after reset");

    // PWM on DUT P: count digit-0 anode-on cycles in 16-cycle windows.
    wait_frame(1);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      case (w)
        0:       p_br = 4'd3;
        1:       p_br = 4'd15;
        default: p_br = 4'd0;
      endcase
      cnt = 0;
      others_ok = 1'b1;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (p_an == 4'b1110) cnt++;
        if (p_an[3:1] != 3'b111) others_ok = 1'b0;
      end
      chk($sformatf("pwm br%0d on-count", p_br), cnt,
          (w == 0) ? 32'd4 : (w == 1) ? 32'd16 : 32'd1);
      chk($sformatf("pwm br%0d other anodes", p_br), {31'd0, others_ok}, 32'd1);
    end

    // Generics on DUT G: active-high, 6 digits, wrap 5 -> 0.
    wait_frame(2);
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      g_exp = ((c % 4) == 3) ? 6'h00 : (6'b000001 << ((c / 4) % 6));
      chk($sformatf("gen an c%0d", c), {26'd0, g_an}, {26'd0, g_exp});
      chk($sformatf("gen cat c%0d", c), {24'd0, g_cat}, 32'h7F);
      chk($sformatf("gen fs c%0d", c), {31'd0, g_fs}, {31'd0, (c == 23)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller, next generation of the 4-digit hex display driver in the top-level board wrapper. It adds:
- NUM_DIGITS-wide hex input, snapshotted once per scan frame so the display never shows a half-updated value.
- Per-digit enable/blank and per-digit decimal point.
- Leading-zero suppression.
- 16-level brightness PWM.
- Configurable anode/cathode polarity.
- Registered outputs and a real synchronous reset.
It sits between the CPU dout register and the board seg_an/seg_cat pins, clocked by clk100.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8).
TICK_DIV, 100_000, clk cycles each digit is selected (>=2).
AN_ACTIVE_LOW, 1, 1 = anodes active-low, 0 = active-high.
CAT_ACTIVE_LOW, 1, 1 = cathodes (incl. DP) active-low, 0 = active-high.

Ports:
clk  in  1  system clock (clk100).
reset  in  1  synchronous, active-high reset.
hex_val  in  4*NUM_DIGITS  value to display; nibble k drives digit k, k=0 is rightmost.
dp_en  in  NUM_DIGITS  bit k lights the DP of digit k.
digit_en  in  NUM_DIGITS  bit k=0 forces digit k blank (anode off).
lz_suppress  in  1  1 = blank leading zero digits.
brightness  in  4  PWM duty; anode on for (brightness+1)/16 of cycles.
seg_an  out  NUM_DIGITS  anode drives, polarity per AN_ACTIVE_LOW.
seg_cat  out  8  {DP,G,F,E,D,C,B,A}, polarity per CAT_ACTIVE_LOW.
frame_start  out  1  one-cycle pulse when digit 0 is entered and the snapshot is taken.

Behaviour:
- Reset: tick_cnt=0, digit_sel=0, pwm_cnt=0, snapshot registers=0, frame_start=0. seg_an and seg_cat are at the inactive level: all anodes off, all cathodes off. All outputs are registered, so they hold these values on the first cycle after reset deasserts.
- tick_cnt counts 0..TICK_DIV-1 and wraps. On wrap, digit_sel advances by 1. digit_sel wraps from NUM_DIGITS-1 to 0. This also holds for non-power-of-2 NUM_DIGITS: digit_sel never exceeds NUM_DIGITS-1.
- Snapshot: in the cycle digit_sel moves to 0, and in the first cycle after reset, capture hex_val, dp_en, digit_en and lz_suppress into snap_* registers. frame_start pulses high in that same cycle. Input changes mid-frame do not affect the display until the next snapshot.
- brightness is not snapshotted; it takes effect on the next pwm compare.
- pwm_cnt is a free-running 4-bit counter incremented every clk; it wraps 15 to 0.
- pwm_on = (pwm_cnt <= brightness). At brightness=15 the anode is on continuously.
- Leading-zero mask, computed from the snapshot: digit k is suppressed when snap_lz=1, every nibble k..NUM_DIGITS-1 is 0, and k != 0. Digit 0 is never suppressed, so value 0 shows a single "0".
- Digit visible = snap_digit_en[digit_sel] AND NOT suppressed[digit_sel].
- Registered output stage, one clk latency from digit_sel/pwm_cnt:
  - seg_an has exactly one bit active, bit digit_sel, when visible AND pwm_on; otherwise all anodes are inactive.
  - seg_cat is the decode of the selected nibble with DP = snap_dp[digit_sel] when visible; otherwise all cathodes are inactive.
- Decode table (active-high segments before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Ghosting guard: in the cycle tick_cnt==TICK_DIV-1, seg_an is forced fully inactive, giving a one-cycle blank before each digit switch.
- Reset asserted mid-scan returns everything to the reset state on the next clk edge. No partial frame is resumed.

Decomposition:
- Package seg7_pkg:
  - localparam SEG_BLANK = 7'h00;
  - function hex_to_seg(4-bit) returning 7-bit active-high segments {G..A};
  - function clog2-safe width helper for digit_sel.
- One natural sub-module: seg7_hex_decoder, a combinational nibble-to-segment wrapper around the package function. It is instantiated once on the muxed nibble.
- Counters, snapshot logic and the output stage stay in seg7_scan_ctrl.

Test Plan:
- Reset/scan order: NUM_DIGITS=4, TICK_DIV=4, hex_val=16'h12AF, brightness=15, digit_en=F, lz=0.
  - After reset, seg_an=1111 and seg_cat=FF.
  - Then seg_an cycles 1110,1101,1011,0111 with cathodes F(8E), A(88), 2(A4), 1(F9).
  - Each digit is held 3 cycles plus 1 blank cycle.
- Snapshot: change hex_val from 16'h1111 to 16'h2222 while digit 1 is active.
  - Digits 2 and 3 still show 1 (F9).
  - All digits show 2 only after the next frame_start pulse.
- Leading zero: hex_val=16'h0030, lz=1.
  - Digits 3 and 2 are blank (anode off).
  - Digit 1 shows 3 and digit 0 shows 0.
  - hex_val=0 shows only digit 0 = "0".
- DP/blank: dp_en=4'b0100 gives digit 2 cathode bit7 active (0). digit_en=4'b1011 keeps anode bit2 inactive for the whole frame.
- PWM: brightness=3, TICK_DIV=64. The selected anode is active for exactly 4 of every 16 consecutive cycles.
- Generics: NUM_DIGITS=6, AN_ACTIVE_LOW=0, CAT_ACTIVE_LOW=0. digit_sel wraps 5 to 0, one seg_an bit is high at a time, and digit 8 gives seg_cat=8'h7F.
